// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: data width, ALU opcodes,
// controller state encoding and the packed status-flag record.
package alu_pkg;

  localparam int DATA_W = 16;

  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0101;
  localparam logic [3:0] OP_SHL = 4'b0110;
  localparam logic [3:0] OP_SHR = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  typedef struct packed {
    logic c;
    logic s;
    logic v;
  } flags_t;

endpackage

// File: rtl/alu_regfile.sv
// Register file: NREGS x DATA_W, one write port and three combinational read
// ports (two operands plus debug). R0 is hard-wired to zero on every read.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_rs1_addr,
  output logic [DATA_W-1:0] o_rs1_data,
  input  logic [AW-1:0]     i_rs2_addr,
  output logic [DATA_W-1:0] o_rs2_data,
  input  logic [AW-1:0]     i_dbg_addr,
  output logic [DATA_W-1:0] o_dbg_data
);

  logic [DATA_W-1:0] r_mem [NREGS];

  // Storage update; writes aimed at R0 are discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_mem[i] <= {DATA_W{1'b0}};
      end
    end else if (i_we && (i_waddr != {AW{1'b0}})) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rs1_data = (i_rs1_addr == {AW{1'b0}}) ? {DATA_W{1'b0}} : r_mem[i_rs1_addr];
  assign o_rs2_data = (i_rs2_addr == {AW{1'b0}}) ? {DATA_W{1'b0}} : r_mem[i_rs2_addr];
  assign o_dbg_data = (i_dbg_addr == {AW{1'b0}}) ? {DATA_W{1'b0}} : r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts one instruction at a time, holds operands on the
// ALU for ALU_LATENCY clocks (1..7), then writes the result back and updates flags.
module alu_issue_ctrl #(
  parameter int ALU_LATENCY = 2,
  parameter int NREGS       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [3:0]  instr_opcode,
  input  logic [2:0]  instr_rd,
  input  logic [2:0]  instr_rs1,
  input  logic [2:0]  instr_rs2,
  input  logic        instr_imm_en,
  input  logic [15:0] instr_imm,
  output logic [3:0]  alu_opcode,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [15:0] alu_result,
  input  logic        alu_carry,
  input  logic        alu_sign,
  input  logic        alu_overflow,
  output logic        wb_valid,
  output logic [2:0]  wb_rd,
  output logic [15:0] wb_data,
  output logic        flag_c,
  output logic        flag_s,
  output logic        flag_v,
  output logic        busy,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] dbg_data
);
  import alu_pkg::*;

  localparam logic [2:0] LAT_C = 3'(ALU_LATENCY);

  state_t            r_state;
  logic [2:0]        r_cnt;
  logic [2:0]        r_rd;
  logic [3:0]        r_alu_op;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic              r_wb_valid;
  logic [2:0]        r_wb_rd;
  logic [DATA_W-1:0] r_wb_data;
  flags_t            r_flags;
  logic              r_ready;
  logic              r_busy;

  logic [DATA_W-1:0] w_rs1_data;
  logic [DATA_W-1:0] w_rs2_data;
  logic [DATA_W-1:0] w_b_operand;
  logic              w_accept;
  logic              w_wr_en;

  // r_ready is high exactly while in IDLE, so this is the handshake.
  assign w_accept    = instr_valid && r_ready;
  assign w_wr_en     = (r_state == ST_CAPTURE);
  assign w_b_operand = instr_imm_en ? instr_imm : w_rs2_data;

  alu_regfile #(
    .NREGS (NREGS),
    .AW    (3)
  ) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_we       (w_wr_en),
    .i_waddr    (r_rd),
    .i_wdata    (alu_result),
    .i_rs1_addr (instr_rs1),
    .o_rs1_data (w_rs1_data),
    .i_rs2_addr (instr_rs2),
    .o_rs2_data (w_rs2_data),
    .i_dbg_addr (dbg_addr),
    .o_dbg_data (dbg_data)
  );

  // Issue FSM with all controller outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 3'd0;
      r_rd       <= 3'd0;
      r_alu_op   <= 4'd0;
      r_alu_a    <= {DATA_W{1'b0}};
      r_alu_b    <= {DATA_W{1'b0}};
      r_wb_valid <= 1'b0;
      r_wb_rd    <= 3'd0;
      r_wb_data  <= {DATA_W{1'b0}};
      r_flags    <= '{c: 1'b0, s: 1'b0, v: 1'b0};
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_alu_op <= instr_opcode;
            r_alu_a  <= w_rs1_data;
            r_alu_b  <= w_b_operand;
            r_rd     <= instr_rd;
            r_cnt    <= 3'd1;
            r_state  <= ST_ISSUE;
            r_ready  <= 1'b0;
            r_busy   <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (r_cnt == LAT_C) begin
            r_state <= ST_CAPTURE;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        ST_CAPTURE: begin
          // Regfile write happens on this same edge via w_wr_en.
          r_wb_valid <= 1'b1;
          r_wb_rd    <= r_rd;
          r_wb_data  <= alu_result;
          r_flags    <= '{c: alu_carry, s: alu_sign, v: alu_overflow};
          r_cnt      <= 3'd0;
          r_state    <= ST_IDLE;
          r_ready    <= 1'b1;
          r_busy     <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= 3'd0;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign instr_ready = r_ready;
  assign busy        = r_busy;
  assign alu_opcode  = r_alu_op;
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign wb_valid    = r_wb_valid;
  assign wb_rd       = r_wb_rd;
  assign wb_data     = r_wb_data;
  assign flag_c      = r_flags.c;
  assign flag_s      = r_flags.s;
  assign flag_v      = r_flags.v;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: three instances (ALU_LATENCY 1, 2, 3) each driven by
// directed plus random instructions and checked against a register-array model.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int NL = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NL-1:0]       rst_n_p, valid_p, immen_p, ready_p, wbv_p, fc_p, fs_p, fv_p, busy_p;
  logic [NL-1:0][3:0]  op_p, aop_p;
  logic [NL-1:0][2:0]  rd_p, rs1_p, rs2_p, wbrd_p, dbga_p;
  logic [NL-1:0][15:0] imm_p, aa_p, ab_p, wbd_p, dbgd_p;

  logic [15:0] ref_r [NL][8];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference ALU behaviour: returns {carry, sign, overflow, result}.
  function automatic logic [18:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] t;
    logic [15:0] r;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    t = 17'h0;
    case (op)
      4'b0100: begin
        t = {1'b0, a} + {1'b0, b};
        r = t[15:0];
        c = t[16];
        v = (a[15] == b[15]) && (r[15] != a[15]);
      end
      4'b0101: begin
        t = {1'b0, a} - {1'b0, b};
        r = t[15:0];
        c = t[16];
        v = (a[15] != b[15]) && (r[15] != a[15]);
      end
      4'b0110: begin
        r = a << 1;
        c = a[15];
      end
      4'b0111: begin
        r = 16'($signed(a) >>> 1);
        c = a[0];
      end
      default: begin
        case (op[1:0])
          2'd0:    r = a & b;
          2'd1:    r = a | b;
          2'd2:    r = a ^ b;
          default: r = ~a;
        endcase
      end
    endcase
    return {c, r[15], v, r};
  endfunction

  task automatic chk(input int ln, input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL L%0d %s got=%0h exp=%0h t=%0t", ln, tag, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < NL; g++) begin : g_lane
    logic [3:0]  last_op = 4'h0;
    logic [15:0] last_a  = 16'h0;
    logic [15:0] last_b  = 16'h0;
    int          age     = 0;
    logic [18:0] f_l;
    logic [15:0] res_l;
    logic        c_l, s_l, v_l;

    // ALU stub: output is only correct once operands have been stable for LAT edges.
    always @(posedge clk) begin
      if (aop_p[g] != last_op || aa_p[g] != last_a || ab_p[g] != last_b) age <= 1;
      else if (age < 16) age <= age + 1;
      last_op <= aop_p[g];
      last_a  <= aa_p[g];
      last_b  <= ab_p[g];
    end

    always_comb begin
      f_l = alu_fn(aop_p[g], aa_p[g], ab_p[g]);
      if (age >= g + 1) {c_l, s_l, v_l, res_l} = f_l;
      else              {c_l, s_l, v_l, res_l} = ~f_l;
    end

    alu_issue_ctrl #(.ALU_LATENCY(g + 1), .NREGS(8)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n_p[g]),
      .instr_valid  (valid_p[g]),
      .instr_ready  (ready_p[g]),
      .instr_opcode (op_p[g]),
      .instr_rd     (rd_p[g]),
      .instr_rs1    (rs1_p[g]),
      .instr_rs2    (rs2_p[g]),
      .instr_imm_en (immen_p[g]),
      .instr_imm    (imm_p[g]),
      .alu_opcode   (aop_p[g]),
      .alu_a        (aa_p[g]),
      .alu_b        (ab_p[g]),
      .alu_result   (res_l),
      .alu_carry    (c_l),
      .alu_sign     (s_l),
      .alu_overflow (v_l),
      .wb_valid     (wbv_p[g]),
      .wb_rd        (wbrd_p[g]),
      .wb_data      (wbd_p[g]),
      .flag_c       (fc_p[g]),
      .flag_s       (fs_p[g]),
      .flag_v       (fv_p[g]),
      .busy         (busy_p[g]),
      .dbg_addr     (dbga_p[g]),
      .dbg_data     (dbgd_p[g])
    );
  end

  task automatic dbg_read(input int ln, input logic [2:0] addr, output logic [15:0] val);
    dbga_p[ln] = addr;
    #1;
    val = dbgd_p[ln];
  endtask

  // Issue one instruction and follow it cycle by cycle to its write-back.
  task automatic do_instr(input int ln, input logic [3:0] op, input logic [2:0] rd,
                          input logic [2:0] rs1, input logic [2:0] rs2, input logic ie,
                          input logic [15:0] imm, input logic hold);
    logic [15:0] a, b, v;
    logic [18:0] f;
    int lat, waited;
    lat = ln + 1;
    op_p[ln] = op; rd_p[ln] = rd; rs1_p[ln] = rs1; rs2_p[ln] = rs2;
    immen_p[ln] = ie; imm_p[ln] = imm; valid_p[ln] = 1'b1;
    waited = 0;
    while (!ready_p[ln] && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk(ln, "accept_ready", ready_p[ln], 1);
    a = ref_r[ln][rs1];
    b = ie ? imm : ref_r[ln][rs2];
    f = alu_fn(op, a, b);
    @(posedge clk);
    for (int i = 1; i <= lat + 2; i++) begin
      @(negedge clk);
      if (i <= lat + 1) begin
        chk(ln, "busy_ready", {busy_p[ln], ready_p[ln], wbv_p[ln]}, 3'b100);
        chk(ln, "alu_op", aop_p[ln], op);
        chk(ln, "alu_a", aa_p[ln], a);
        chk(ln, "alu_b", ab_p[ln], b);
      end else begin
        chk(ln, "wb_pulse", {busy_p[ln], ready_p[ln], wbv_p[ln]}, 3'b011);
        chk(ln, "wb_rd", wbrd_p[ln], rd);
        chk(ln, "wb_data", wbd_p[ln], f[15:0]);
        chk(ln, "flags", {fc_p[ln], fs_p[ln], fv_p[ln]}, f[18:16]);
        if (rd != 3'd0) ref_r[ln][rd] = f[15:0];
        dbg_read(ln, rd, v);
        chk(ln, "dbg_wb", v, ref_r[ln][rd]);
      end
    end
    if (!hold) valid_p[ln] = 1'b0;
  endtask

  task automatic run_lane(input int ln);
    int lat;
    logic [15:0] v;
    lat = ln + 1;
    rst_n_p[ln] = 1'b0; valid_p[ln] = 1'b0; op_p[ln] = 4'h0; rd_p[ln] = 3'd0;
    rs1_p[ln] = 3'd0; rs2_p[ln] = 3'd0; immen_p[ln] = 1'b0; imm_p[ln] = 16'h0; dbga_p[ln] = 3'd0;
    for (int i = 0; i < 8; i++) ref_r[ln][i] = 16'h0;
    repeat (3) @(negedge clk);
    rst_n_p[ln] = 1'b1;
    @(negedge clk);
    chk(ln, "rst_ctrl", {ready_p[ln], busy_p[ln], wbv_p[ln]}, 3'b100);
    chk(ln, "rst_flags", {fc_p[ln], fs_p[ln], fv_p[ln]}, 3'b000);
    chk(ln, "rst_alu", {aop_p[ln], aa_p[ln], ab_p[ln]}, 36'h0);
    chk(ln, "rst_wb", {wbrd_p[ln], wbd_p[ln]}, 19'h0);
    for (int i = 0; i < 8; i++) begin
      dbg_read(ln, 3'(i), v);
      chk(ln, "rst_reg", v, 16'h0);
    end

    // Reset asserted while the instruction is in ISSUE: nothing may be written back.
    op_p[ln] = OP_ADD; rd_p[ln] = 3'd1; rs1_p[ln] = 3'd0; immen_p[ln] = 1'b1;
    imm_p[ln] = 16'd5; valid_p[ln] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_p[ln] = 1'b0;
    chk(ln, "mid_busy", busy_p[ln], 1);
    rst_n_p[ln] = 1'b0;
    #1;
    chk(ln, "mid_rst_ctrl", {ready_p[ln], busy_p[ln], wbv_p[ln]}, 3'b100);
    chk(ln, "mid_rst_alu", aa_p[ln], 16'h0);
    @(negedge clk);
    rst_n_p[ln] = 1'b1;
    for (int i = 0; i < lat + 3; i++) begin
      @(negedge clk);
      chk(ln, "mid_no_wb", {ready_p[ln], wbv_p[ln]}, 2'b10);
    end
    dbg_read(ln, 3'd1, v);
    chk(ln, "mid_r1", v, 16'h0);

    do_instr(ln, OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'h7FFF, 1'b0);
    dbg_read(ln, 3'd1, v);
    chk(ln, "r1_7fff", v, 16'h7FFF);
    do_instr(ln, OP_ADD, 3'd2, 3'd1, 3'd0, 1'b1, 16'h0001, 1'b0);
    dbg_read(ln, 3'd2, v);
    chk(ln, "r2_8000", v, 16'h8000);
    chk(ln, "ovf_csv", {fc_p[ln], fs_p[ln], fv_p[ln]}, 3'b011);

    do_instr(ln, OP_ADD, 3'd3, 3'd0, 3'd0, 1'b1, 16'd5, 1'b0);
    do_instr(ln, OP_ADD, 3'd4, 3'd0, 3'd0, 1'b1, 16'd7, 1'b0);
    do_instr(ln, OP_SUB, 3'd5, 3'd3, 3'd4, 1'b0, 16'h1234, 1'b0);
    dbg_read(ln, 3'd5, v);
    chk(ln, "r5_fffe", v, 16'hFFFE);
    chk(ln, "sub_csv", {fc_p[ln], fs_p[ln], fv_p[ln]}, 3'b110);

    // Dependent chain with instr_valid held high between instructions.
    do_instr(ln, 4'b0011, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0000, 1'b0);
    do_instr(ln, OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0000, 1'b0);
    for (int i = 0; i < 4; i++) do_instr(ln, OP_ADD, 3'd1, 3'd1, 3'd0, 1'b1, 16'h0001, i < 3);
    dbg_read(ln, 3'd1, v);
    chk(ln, "chain_r1", v, 16'd4);

    do_instr(ln, 4'b0001, 3'd0, 3'd0, 3'd0, 1'b1, 16'hFFFF, 1'b0);
    chk(ln, "r0_wbdata", wbd_p[ln], 16'hFFFF);
    dbg_read(ln, 3'd0, v);
    chk(ln, "r0_zero", v, 16'h0);

    for (int n = 0; n < 40; n++) begin
      do_instr(ln, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
               3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 16'($urandom),
               (n < 39) ? 1'($urandom_range(0, 1)) : 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      dbg_read(ln, 3'(i), v);
      chk(ln, "final_reg", v, ref_r[ln][i]);
    end
  endtask

  initial begin
    fork
      run_lane(0);
      run_lane(1);
      run_lane(2);
    join
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
